// File: rtl/univ_shift_reg_param.sv
// rtl/univ_shift_reg_param.sv - parametrised universal shift register with multi-step burst engine
module univ_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             L,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             SI_R,
    input  logic             SI_L,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [2:0]       op_r, op_next;
    logic [AMT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_next, step_q;
    logic             busy_next, done_next;

    assign SO_R = Q[0];
    assign SO_L = Q[WIDTH-1];

    // Serial inputs are used live on every step, never latched with op.
    always_comb begin
        step_q = Q;
        case (op_r)
            3'd0:    step_q = {SI_R, Q[WIDTH-1:1]};
            3'd1:    step_q = {Q[WIDTH-2:0], SI_L};
            3'd2:    step_q = {Q[0], Q[WIDTH-1:1]};
            3'd3:    step_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
            3'd4:    step_q = {Q[WIDTH-1], Q[WIDTH-1:1]};
            3'd5:    step_q = {Q[WIDTH-2:0], 1'b0};
            default: step_q = Q;
        endcase
    end

    always_comb begin
        state_next = state;
        q_next     = Q;
        op_next    = op_r;
        cnt_next   = cnt;
        busy_next  = busy;
        done_next  = 1'b0;
        if (L) begin
            // Load wins over any burst activity and aborts without a done pulse.
            q_next     = D;
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (amt != '0) begin
                            op_next    = op;
                            cnt_next   = amt;
                            busy_next  = 1'b1;
                            state_next = SHIFT;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    q_next   = step_q;
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Q     <= '0;
            op_r  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            Q     <= q_next;
            op_r  <= op_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

endmodule
